// File: rtl/hvsync_pkg.sv
// Video timing constants for the 256x240 raster, shared by the sync generator,
// the terminal and the top-level RGB gating.
package hvsync_pkg;

  localparam int H_DISPLAY = 256;
  localparam int H_BACK    = 23;
  localparam int H_FRONT   = 7;
  localparam int H_SYNC    = 23;
  localparam int V_DISPLAY = 240;
  localparam int V_TOP     = 5;
  localparam int V_BOTTOM  = 14;
  localparam int V_SYNC    = 3;

  localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
  localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int POS_W = 9;

  // Inclusive range test on a 9-bit counter value; zero-extends before comparing.
  function automatic logic in_range(input logic [POS_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/hvsync_generator.sv
// Free-running pixel/line counters with registered sync pulses and a
// combinational display-enable for the 256x240 active area.
module hvsync_generator
  import hvsync_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos
);

  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hmax;
  logic             vmax;

  always_comb begin
    hmax    = (hpos_q == POS_W'(H_MAX));
    vmax    = (vpos_q == POS_W'(V_MAX));
    hpos_d  = hmax ? '0 : hpos_q + POS_W'(1);
    vpos_d  = vpos_q;
    if (hmax) begin
      vpos_d = vmax ? '0 : vpos_q + POS_W'(1);
    end
    // Sync flops sample the current position, so they lag the counters by one clock.
    hsync_d = in_range(hpos_q, H_SYNC_START, H_SYNC_END);
    vsync_d = in_range(vpos_q, V_SYNC_START, V_SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = (hpos_q < POS_W'(H_DISPLAY)) && (vpos_q < POS_W'(V_DISPLAY));

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench for hvsync_generator: reset state, first line, one full frame,
// and a mid-frame reset while hsync is asserted.
module tb_hvsync_generator;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [8:0] hpos;
  logic [8:0] vpos;

  hvsync_generator dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // expected raster state, advanced once per rising edge
  int eh, ev;
  bit ehs, evs;

  int mism;
  int h256_cnt, de_cnt, de_late, hs_cnt, hs_first, hs_last;
  int hs_rise, vs_rise, vs_cnt, vs_first_v;
  bit prev_hs, prev_vs;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    mism = 0; h256_cnt = 0; de_cnt = 0; de_late = 0; hs_cnt = 0;
    hs_first = -1; hs_last = -1; hs_rise = 0; vs_rise = 0; vs_cnt = 0;
    vs_first_v = -1; prev_hs = 1'b0; prev_vs = 1'b0;
  endtask

  task automatic observe();
    bit exp_de;
    exp_de = (eh < 256) && (ev < 240);
    if (int'(hpos) != eh || int'(vpos) != ev || hsync !== ehs || vsync !== evs ||
        display_on !== exp_de)
      mism++;
    if (hpos == 9'd256) h256_cnt++;
    if (display_on) begin
      de_cnt++;
      if (vpos >= 9'd240) de_late++;
    end
    if (hsync) begin
      hs_cnt++;
      if (hs_first < 0) hs_first = int'(hpos);
      hs_last = int'(hpos);
      if (!prev_hs) hs_rise++;
    end
    if (vsync) begin
      vs_cnt++;
      if (vs_first_v < 0) vs_first_v = int'(vpos);
      if (!prev_vs) vs_rise++;
    end
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      eh = 0; ev = 0; ehs = 1'b0; evs = 1'b0;
    end else begin
      ehs = (eh >= 263) && (eh <= 285);
      evs = (ev >= 254) && (ev <= 256);
      if (eh == 308) begin
        eh = 0;
        ev = (ev == 261) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit reached;
    reset = 1'b1;
    eh = 0; ev = 0; ehs = 1'b0; evs = 1'b0;
    clear_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_hpos", int'(hpos), 0);
    chk("rst_vpos", int'(vpos), 0);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_display_on", int'(display_on), 1);

    // first line
    for (int i = 0; i < 309; i++) begin
      observe();
      tick();
    end
    chk("line0_h256_count", h256_cnt, 1);
    chk("line0_de_count", de_cnt, 256);
    chk("line0_hsync_width", hs_cnt, 23);
    chk("line0_hsync_first_hpos", hs_first, 264);
    chk("line0_hsync_last_hpos", hs_last, 286);
    chk("line1_hpos", int'(hpos), 0);
    chk("line1_vpos", int'(vpos), 1);

    // remainder of the frame; stats keep accumulating from reset release
    for (int i = 309; i < 80958; i++) begin
      observe();
      tick();
    end
    chk("frame_hsync_rises", hs_rise, 262);
    chk("frame_h256_count", h256_cnt, 262);
    chk("frame_vsync_rises", vs_rise, 1);
    chk("frame_vsync_width", vs_cnt, 927);
    chk("frame_vsync_first_vpos", vs_first_v, 254);
    chk("frame_de_count", de_cnt, 61440);
    chk("frame_de_blank_rows", de_late, 0);
    chk("frame_cycle_mismatches", mism, 0);
    chk("frame_wrap_hpos", int'(hpos), 0);
    chk("frame_wrap_vpos", int'(vpos), 0);

    // walk to (270,3) where hsync is asserted, then pulse reset
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if (eh == 270 && ev == 3) reached = 1'b1;
      else tick();
    end
    chk("reach_270_3", int'(reached), 1);
    chk("pre_reset_hsync", int'(hsync), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_hpos", int'(hpos), 0);
    chk("midrst_vpos", int'(vpos), 0);
    chk("midrst_hsync", int'(hsync), 0);
    chk("midrst_vsync", int'(vsync), 0);

    clear_stats();
    for (int i = 0; i < 309; i++) begin
      observe();
      tick();
    end
    chk("restart_mismatches", mism, 0);
    chk("restart_hsync_width", hs_cnt, 23);
    chk("restart_vpos", int'(vpos), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
